// File: rtl/rc4_pkg.sv
// rc4_pkg: shared widths and types for the RC4 key-search datapath
package rc4_pkg;
  localparam int MSG_LEN = 32;
  localparam int MSG_ADDR_W = 5;
  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, search starts just after ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int W = $clog2(N);
  logic found;
  logic [W-1:0] idx;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = idx;
      end
    end
  end
endmodule

// File: rtl/msg_rom_arbiter.sv
// msg_rom_arbiter: round-robin sharing of the message ROM read port, tagged broadcast read data
module msg_rom_arbiter
  import rc4_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR_W = MSG_ADDR_W,
  parameter int DATA_W = BYTE_W,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [DATA_W-1:0]       rdata,
  output logic [N_REQ-1:0]        rdata_valid,
  output logic                    busy
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] ptr, gnt_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic [ADDR_W-1:0] last_addr;
  // one-hot owner per stage; all-zero marks an empty slot
  logic [ROM_LAT-1:0][N_REQ-1:0] tags;
  rr_arbiter #(.N(N_REQ)) u_arb (.req(req), .ptr(ptr), .gnt(arb_gnt), .gnt_idx(gnt_idx));
  always_comb begin
    gnt = reset ? '0 : arb_gnt;
    rom_address = |gnt ? req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] : last_addr;
    rdata = rom_q;
    rdata_valid = reset ? '0 : tags[ROM_LAT-1];
    busy = |req || |tags;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PW'(N_REQ - 1);
      last_addr <= '0;
      tags <= '0;
    end else begin
      if (|gnt) begin
        ptr <= gnt_idx;
        last_addr <= rom_address;
      end
      tags[0] <= gnt;
      for (int i = 1; i < ROM_LAT; i++) tags[i] <= tags[i-1];
    end
  end
endmodule
